vector_line_gen: RTL

- Vector line generator for the XY (oscilloscope) vector display.
- Sits directly upstream of the X/Y channel outputs; replaces the free-running ramp counters with real segment drawing.
- Accepts one line segment per valid/ready handshake and walks it with Bresenham's algorithm, one point per step tick.
- Drives x_ch/y_ch (to the DAC stage) and a beam_on (Z/blank) strobe.

---
 rtl/vector_pkg.sv | 33 +++
 rtl/step_tick_gen.sv | 33 +++
 rtl/vector_line_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_pkg : shared types and widths for the XY vector generator   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package vector_pkg;

  localparam int VEC_CH_W = 8;

  // Bresenham error term needs a sign bit plus one bit of headroom
  function automatic int err_width(input int ch_w);
    return ch_w + 2;
  endfunction

  localparam int ERR_W = err_width(VEC_CH_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } vec_state_t;

  typedef struct packed {
    logic                blank;
    logic [VEC_CH_W-1:0] x0;
    logic [VEC_CH_W-1:0] y0;
    logic [VEC_CH_W-1:0] x1;
    logic [VEC_CH_W-1:0] y1;
  } vec_seg_t;

endpackage
`default_nettype wire

// File: rtl/step_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | step_tick_gen : one-cycle clock-enable pulse every DIV cycles      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module step_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);
  assign tick   = enable && w_wrap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vector_line_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vector_line_gen : Bresenham segment walker driving XY DAC channels |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module vector_line_gen
  import vector_pkg::*;
#(
  parameter int CH_WIDTH = VEC_CH_W,
  parameter int STEP_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic                seg_blank,
  input  logic [CH_WIDTH-1:0] seg_x0,
  input  logic [CH_WIDTH-1:0] seg_y0,
  input  logic [CH_WIDTH-1:0] seg_x1,
  input  logic [CH_WIDTH-1:0] seg_y1,
  output logic [CH_WIDTH-1:0] x_ch,
  output logic [CH_WIDTH-1:0] y_ch,
  output logic                beam_on,
  output logic                busy,
  output logic                seg_done
);

  localparam int EW = err_width(CH_WIDTH);

  vec_state_t r_state, w_state_nxt;
  vec_seg_t   r_seg;

  logic [CH_WIDTH-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic signed [EW-1:0] r_dx, r_dy, r_err, w_err_nxt;
  logic signed [EW-1:0] w_x0s, w_y0s, w_x1s, w_y1s, w_dxr, w_dyr, w_dx, w_dy;
  logic signed [EW:0]   w_e2, w_dx_ext, w_dy_ext;
  logic r_sx_neg, r_sy_neg, r_beam, w_beam_nxt, r_live;
  logic w_tick, w_accept, w_stepx, w_stepy, w_at_end;

  step_tick_gen #(.DIV(STEP_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (w_tick)
  );

  // r_live holds seg_ready low until the first edge after reset release
  assign seg_ready = r_live && (r_state == IDLE);
  assign busy      = (r_state == SETUP) || (r_state == DRAW);
  assign seg_done  = (r_state == DONE);
  assign beam_on   = r_beam;
  assign x_ch      = r_x;
  assign y_ch      = r_y;
  assign w_accept  = seg_valid && seg_ready;

  assign w_x0s = {2'b00, r_seg.x0};
  assign w_y0s = {2'b00, r_seg.y0};
  assign w_x1s = {2'b00, r_seg.x1};
  assign w_y1s = {2'b00, r_seg.y1};
  assign w_dxr = w_x1s - w_x0s;
  assign w_dyr = w_y1s - w_y0s;
  assign w_dx  = w_dxr[EW-1] ? -w_dxr : w_dxr;
  assign w_dy  = w_dyr[EW-1] ? w_dyr : -w_dyr;

  assign w_e2     = {r_err, 1'b0};
  assign w_dx_ext = {r_dx[EW-1], r_dx};
  assign w_dy_ext = {r_dy[EW-1], r_dy};
  assign w_stepx  = (w_e2 >= w_dy_ext);
  assign w_stepy  = (w_e2 <= w_dx_ext);
  assign w_at_end = (r_x == r_seg.x1) && (r_y == r_seg.y1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_err_nxt   = r_err;
    w_beam_nxt  = r_beam;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = DRAW;
        w_err_nxt   = w_dx + w_dy;
        w_beam_nxt  = !r_seg.blank;
        // a blanked move jumps straight to its endpoint
        w_x_nxt     = r_seg.blank ? r_seg.x1 : r_seg.x0;
        w_y_nxt     = r_seg.blank ? r_seg.y1 : r_seg.y0;
      end
      DRAW: begin
        if (w_tick) begin
          if (w_at_end) begin
            w_state_nxt = DONE;
            w_beam_nxt  = 1'b0;
          end else begin
            w_err_nxt = r_err + (w_stepx ? r_dy : '0) + (w_stepy ? r_dx : '0);
            if (w_stepx) w_x_nxt = r_sx_neg ? r_x - 1'b1 : r_x + 1'b1;
            if (w_stepy) w_y_nxt = r_sy_neg ? r_y - 1'b1 : r_y + 1'b1;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_err    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
      r_beam   <= 1'b0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_err  <= w_err_nxt;
      r_beam <= w_beam_nxt;
      if (w_accept) begin
        r_seg <= '{blank: seg_blank, x0: seg_x0, y0: seg_y0, x1: seg_x1, y1: seg_y1};
      end
      if (r_state == SETUP) begin
        r_dx     <= w_dx;
        r_dy     <= w_dy;
        r_sx_neg <= !(r_seg.x0 < r_seg.x1);
        r_sy_neg <= !(r_seg.y0 < r_seg.y1);
      end
    end
  end

endmodule
`default_nettype wire
